// File: rtl/uart_receiver.sv
// 8N1 UART receiver on the clk_50m domain, oversampled by the shared clken tick.
// Completed bytes are held in data with a rdy/rdy_clr handshake plus frame-error and overrun flags.
module uart_receiver #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic       clken,
   input  logic       rx,
   input  logic       rdy_clr,
   output logic [7:0] data,
   output logic       rdy,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] MID_START = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] MID_BIT   = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   state_t                 state, state_nx;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic [SW-1:0]          sample, sample_nx;
   logic [2:0]             bitpos, bitpos_nx;
   logic [7:0]             shift_reg, shift_nx;
   logic                   done_ok, done_err;

   // Flops preset to 1 so reset looks like an idle line, not a start bit.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sample    <= '0;
         bitpos    <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_nx;
         sample    <= sample_nx;
         bitpos    <= bitpos_nx;
         shift_reg <= shift_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      sample_nx = sample;
      bitpos_nx = bitpos;
      shift_nx  = shift_reg;
      done_ok   = 1'b0;
      done_err  = 1'b0;
      if (clken) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nx  = START;
                  sample_nx = '0;
               end
            end
            START: begin
               if (sample == MID_START) begin
                  if (!rx_s) begin
                     state_nx  = DATA;
                     sample_nx = '0;
                     bitpos_nx = '0;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  sample_nx = sample + 1'b1;
               end
            end
            DATA: begin
               if (sample == MID_BIT) begin
                  shift_nx[bitpos] = rx_s;
                  sample_nx        = '0;
                  if (bitpos == 3'd7) state_nx  = STOP;
                  else                bitpos_nx = bitpos + 1'b1;
               end else begin
                  sample_nx = sample + 1'b1;
               end
            end
            STOP: begin
               if (sample == MID_BIT) begin
                  sample_nx = '0;
                  bitpos_nx = '0;
                  if (rx_s) begin
                     done_ok  = 1'b1;
                     state_nx = IDLE;
                  end else begin
                     done_err = 1'b1;
                     state_nx = WAIT_IDLE;
                  end
               end else begin
                  sample_nx = sample + 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // A completing frame overrides a simultaneous rdy_clr.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         data      <= 8'h00;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (rdy_clr) begin
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         if (done_ok) begin
            data      <= shift_reg;
            rdy       <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= rdy & ~rdy_clr;
         end
         if (done_err) frame_err <= 1'b1;
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART serial receiver, the receive-side counterpart of the team's 8N1 transmitter on the same clk_50m domain. It samples the asynchronous rx line using a 16x-baud clock-enable (clken) from the shared baud generator. It deframes 1 start bit, 8 data bits (LSB first) and 1 stop bit. Each completed byte is presented on a parallel output with a ready/clear handshake, plus frame-error and overrun flags.

Parameters:
OVERSAMPLE, 16, clken ticks per bit period; power of two, minimum 8.
SYNC_STAGES, 2, number of flip-flops in the rx metastability synchroniser; minimum 2.

Ports:
clk_50m  input  1  system clock; all logic on its rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
clken  input  1  single-cycle pulse at OVERSAMPLE x baud rate.
rx  input  1  asynchronous serial line; idles high.
rdy_clr  input  1  single-cycle pulse; consumer acknowledges data and clears flags.
data  output  8  last correctly framed byte.
rdy  output  1  a byte is waiting in data.
frame_err  output  1  last frame had a low stop bit.
overrun  output  1  a byte was overwritten before being acknowledged.
rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): data=8'h00; rdy, frame_err, overrun = 0; state=IDLE; sample counter=0; bitpos=0; all synchroniser flops=1.
- rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- All counters and the FSM advance only on cycles where clken=1. Output handshakes (rdy_clr) act on any clk_50m cycle.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE (3-bit encoding).
- IDLE: on clken with rx_s=0, go to START and set sample=0.
- START: increment sample on each clken. When sample reaches OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA with sample=0, bitpos=0.
  - rx_s=1: treat as a glitch and return to IDLE. No flags change.
- DATA: increment sample on each clken. When sample reaches OVERSAMPLE-1 (mid bit):
  - shift_reg[bitpos] <= rx_s; sample <= 0.
  - If bitpos=7, go to STOP; otherwise bitpos increments.
  - bitpos is 3 bits and wraps only via the STOP transition.
- STOP: when sample reaches OVERSAMPLE-1:
  - rx_s=1: data <= shift_reg, rdy <= 1, frame_err <= 0. If rdy was already 1 and rdy_clr is not asserted in this cycle, overrun <= 1. Go to IDLE.
  - rx_s=0: frame_err <= 1; data and rdy are unchanged; go to WAIT_IDLE.
- WAIT_IDLE: on clken with rx_s=1, go to IDLE. A line held low (break) produces no further frames or errors.
- rdy_clr: clears rdy, frame_err and overrun one cycle later.
  - If byte completion coincides with rdy_clr, completion wins: rdy=1, overrun=0, frame_err reflects the new frame.
- Latency: rdy rises on the clk_50m edge that follows the clken at mid stop bit, about 9.5 bit times after the start-bit falling edge plus synchroniser delay.
- rx_busy = (state != IDLE), combinational from the state register.
- Reset mid-frame discards the partial byte. Reception resumes cleanly on the next falling edge after rst_n deasserts.
- The clken rate is the integrator's responsibility. The block tolerates clken held high continuously (then 1 bit = OVERSAMPLE clocks).

Test Plan:
- Idle line, clken=1 every cycle, rx=1 for 500 cycles -> rx_busy=0, rdy=0, data=8'h00 throughout.
- Frame 0xA5 at 16 clocks/bit (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data=8'hA5, rdy=1, frame_err=0. rdy_clr pulse -> rdy=0 next cycle, data holds 8'hA5.
- Glitch: rx low for 4 clken ticks then high -> FSM returns to IDLE after the mid-start check, rdy=0, frame_err=0. A following frame 0x3C is received correctly.
- Frame 0x3C with stop bit 0 and rx held low 40 bit times -> frame_err=1, rdy=0, data unchanged, rx_busy=1 until rx returns high. The next valid frame 0x0F gives data=8'h0F, frame_err=0.
- Frames 0x11 then 0x22 with no rdy_clr -> data=8'h22, rdy=1, overrun=1. A rdy_clr pulse clears rdy and overrun. Repeat with rdy_clr landing on the completion cycle of 0x22 -> rdy=1, overrun=0.
- rst_n asserted low during data bit 3 of 0x5A -> all outputs reset immediately. After release, frame 0x5A gives data=8'h5A, rdy=1.
